q_sys_fifo_clr_seq: RTL and testbench

Q_SYS_FIFO_CLR_SEQ -- requirements
Module: q_sys_fifo_clr_seq

---
 rtl/q_sys_fifo_clr_seq_if.sv | 12 +
 rtl/q_sys_fifo_clr_seq.sv | 77 +++++++
 tb/tb_q_sys_fifo_clr_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/q_sys_fifo_clr_seq_if.sv
// q_sys_fifo_clr_seq_if: Avalon-MM slave port plus FIFO clear and interrupt outputs
interface q_sys_fifo_clr_seq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        fifo_clr;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, fifo_clr, irq);
    modport slave (input address, chipselect, write_n, writedata, output readdata, fifo_clr, irq);
endinterface

// File: rtl/q_sys_fifo_clr_seq.sv
// q_sys_fifo_clr_seq: register-driven FIFO clear pulse sequencer with hold-off and done interrupt
module q_sys_fifo_clr_seq #(
    parameter int unsigned DEF_PULSE = 4,
    parameter int unsigned DEF_HOLD  = 8
) (
    input logic clk,
    input logic reset_n,
    q_sys_fifo_clr_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;
    state_t state;
    logic [7:0] cnt, pulse_len, holdoff, hold_q;
    logic done, irq_en, fifo_clr_q, irq_q;
    logic wr, start, abort, clr_done, busy;
    logic unused_wd;
    always_comb begin
        wr = bus.chipselect && !bus.write_n;
        start = wr && bus.address == 2'd0 && bus.writedata[0];
        abort = wr && bus.address == 2'd0 && bus.writedata[1];
        clr_done = wr && bus.address == 2'd3 && bus.writedata[1];
        busy = state != IDLE;
        bus.readdata = bus.address == 2'd0 ? {29'd0, fifo_clr_q, done, busy} :
                       bus.address == 2'd1 ? {24'd0, pulse_len} :
                       bus.address == 2'd2 ? {24'd0, holdoff} : {31'd0, irq_en};
    end
    assign unused_wd = ^bus.writedata[31:8];
    assign bus.fifo_clr = fifo_clr_q;
    assign bus.irq = irq_q;
    // done-set assignments follow the IRQCTL clear so a same-edge set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= 8'd0;
            pulse_len <= 8'(DEF_PULSE);
            holdoff <= 8'(DEF_HOLD);
            hold_q <= 8'd0;
            done <= 1'b0;
            irq_en <= 1'b0;
            fifo_clr_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            irq_q <= done && irq_en;
            if (wr && bus.address == 2'd1) pulse_len <= bus.writedata[7:0];
            if (wr && bus.address == 2'd2) holdoff <= bus.writedata[7:0];
            if (wr && bus.address == 2'd3) irq_en <= bus.writedata[0];
            if (clr_done) done <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    state <= ASSERT;
                    fifo_clr_q <= 1'b1;
                    cnt <= pulse_len == 8'd0 ? 8'd1 : pulse_len;
                    hold_q <= holdoff;
                    done <= 1'b0;
                end
                ASSERT: if (abort) begin
                    state <= IDLE;
                    fifo_clr_q <= 1'b0;
                    cnt <= 8'd0;
                end else if (cnt <= 8'd1) begin
                    fifo_clr_q <= 1'b0;
                    state <= hold_q != 8'd0 ? HOLD : IDLE;
                    cnt <= hold_q;
                    if (hold_q == 8'd0) done <= 1'b1;
                end else cnt <= cnt - 8'd1;
                HOLD: if (abort) begin
                    state <= IDLE;
                    cnt <= 8'd0;
                end else if (cnt <= 8'd1) begin
                    state <= IDLE;
                    cnt <= 8'd0;
                    done <= 1'b1;
                end else cnt <= cnt - 8'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_q_sys_fifo_clr_seq.sv
// tb_q_sys_fifo_clr_seq: table, directed and random checks against a timeline model of the sequencer
module tb_q_sys_fifo_clr_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    q_sys_fifo_clr_seq_if bus ();
    q_sys_fifo_clr_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int k = 0, m_s = 0, m_p = 0, m_h = 0;
    logic m_act, m_done, m_en, m_irq;
    logic [7:0] m_pl, m_ho;

    typedef struct {logic [1:0] a; logic cs; logic wn; logic [31:0] wd; logic [31:0] exp;} vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_act = 0; m_done = 0; m_en = 0; m_irq = 0; m_pl = 8'd4; m_ho = 8'd8;
    endtask

    // A sequence started at edge s is busy through edge s+P+H-1 and drives fifo_clr through s+P-1
    task automatic m_step(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        logic w, busy0, done0, en0;
        k++;
        w = cs && !wn; busy0 = m_act; done0 = m_done; en0 = m_en;
        if (w && a == 2'd3 && wd[1]) m_done = 0;
        if (m_act && w && a == 2'd0 && wd[1]) m_act = 0;
        else if (m_act && k == m_s + m_p + m_h) begin m_act = 0; m_done = 1; end
        if (!busy0 && w && a == 2'd0 && wd[0] && !wd[1]) begin
            m_act = 1; m_s = k; m_p = (m_pl == 0) ? 1 : int'(m_pl); m_h = int'(m_ho); m_done = 0;
        end
        m_irq = done0 && en0;
        if (w && a == 2'd1) m_pl = wd[7:0];
        if (w && a == 2'd2) m_ho = wd[7:0];
        if (w && a == 2'd3) m_en = wd[0];
    endtask

    function automatic logic m_fifo();
        return m_act && k < m_s + m_p;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0: return {29'd0, m_fifo(), m_done, m_act};
            2'd1: return {24'd0, m_pl};
            2'd2: return {24'd0, m_ho};
            default: return {31'd0, m_en};
        endcase
    endfunction

    task automatic cyc(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd;
        @(posedge clk);
        m_step(a, cs, wn, wd);
        #1;
        chk("fifo_clr", {31'd0, bus.fifo_clr}, {31'd0, m_fifo()});
        chk("irq", {31'd0, bus.irq}, {31'd0, m_irq});
        chk("readdata", bus.readdata, exp_rd(a));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        cyc(a, 1'b1, 1'b0, wd);
    endtask

    task automatic idle(input logic [1:0] a);
        cyc(a, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic run_seq(output int hi, output int dn, output int iq);
        wr(2'd0, 32'h1);
        hi = int'(bus.fifo_clr); dn = -1; iq = -1;
        for (int i = 1; i <= 40; i++) begin
            idle(2'd0);
            hi += int'(bus.fifo_clr);
            if (dn < 0 && bus.readdata[1]) dn = i;
            if (iq < 0 && bus.irq) iq = i;
        end
    endtask

    initial begin
        int hi, dn, iq;
        logic [1:0] ra;
        logic [31:0] rd;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
        m_reset();
        #2;
        chk("rst_fifo_clr", {31'd0, bus.fifo_clr}, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        #20 reset_n = 1'b1;

        tbl[0]  = '{2'd1, 1'b1, 1'b1, 32'h0,        32'h4};
        tbl[1]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h8};
        tbl[2]  = '{2'd3, 1'b1, 1'b1, 32'h0,        32'h0};
        tbl[3]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'h0};
        tbl[4]  = '{2'd1, 1'b1, 1'b0, 32'h1FF,      32'hFF};
        tbl[5]  = '{2'd1, 1'b0, 1'b0, 32'h12,       32'hFF};
        tbl[6]  = '{2'd2, 1'b1, 1'b0, 32'hABCD00,   32'h0};
        tbl[7]  = '{2'd2, 1'b1, 1'b0, 32'h8,        32'h8};
        tbl[8]  = '{2'd1, 1'b1, 1'b0, 32'hF0000004, 32'h4};
        tbl[9]  = '{2'd3, 1'b1, 1'b0, 32'hFFFFFFFD, 32'h1};
        tbl[10] = '{2'd3, 1'b1, 1'b0, 32'h2,        32'h0};
        tbl[11] = '{2'd0, 1'b1, 1'b0, 32'h2,        32'h0};
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd);
            chk($sformatf("tbl%0d", i), bus.readdata, tbl[i].exp);
        end

        run_seq(hi, dn, iq);
        chk("dflt_pulse_cycles", hi, 4);
        chk("dflt_done_edge", dn, 12);
        chk("dflt_ctrl", bus.readdata, 32'h2);

        wr(2'd1, 32'h0); wr(2'd2, 32'h0);
        run_seq(hi, dn, iq);
        chk("zero_pulse_cycles", hi, 1);
        chk("zero_done_edge", dn, 1);

        wr(2'd1, 32'd20); wr(2'd2, 32'h8); wr(2'd3, 32'h1);
        wr(2'd0, 32'h1);
        for (int i = 1; i <= 4; i++) idle(2'd0);
        wr(2'd0, 32'h2);
        chk("abort_fifo_clr", {31'd0, bus.fifo_clr}, 32'd0);
        chk("abort_ctrl", bus.readdata, 32'h0);
        for (int i = 0; i < 3; i++) idle(2'd0);
        chk("abort_irq", {31'd0, bus.irq}, 32'd0);

        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        hi = int'(bus.fifo_clr); dn = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 7) wr(2'd1, 32'd2);
            else if (i == 8) wr(2'd0, 32'h1);
            else idle(2'd0);
            hi += int'(bus.fifo_clr);
            if (dn < 0 && exp_rd(2'd0) == 32'h2 && bus.readdata == 32'h2) dn = i;
        end
        chk("busy_pulse_cycles", hi, 4);
        chk("busy_done_edge", dn, 12);
        run_seq(hi, dn, iq);
        chk("next_pulse_cycles", hi, 2);
        chk("next_done_edge", dn, 10);
        chk("irq_lag", iq, dn + 1);

        wr(2'd3, 32'h3);
        chk("irqclr_done", bus.readdata, 32'h1);
        idle(2'd0);
        chk("irqclr_ctrl", bus.readdata, 32'h0);
        chk("irqclr_irq", {31'd0, bus.irq}, 32'd0);

        wr(2'd0, 32'h1);
        for (int i = 1; i < 2 + 8; i++) idle(2'd0);
        wr(2'd3, 32'h3);
        idle(2'd0);
        chk("setclr_done", bus.readdata, 32'h2);

        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        idle(2'd0);
        #2 reset_n = 1'b0;
        #1 chk("async_fifo_clr", {31'd0, bus.fifo_clr}, 32'd0);
        bus.address = 2'd1;
        #1 chk("rst_pulse_len", bus.readdata, 32'h4);
        bus.address = 2'd2;
        #1 chk("rst_holdoff", bus.readdata, 32'h8);
        m_reset();
        reset_n = 1'b1;
        run_seq(hi, dn, iq);
        chk("post_rst_pulse", hi, 4);
        chk("post_rst_done", dn, 12);

        for (int i = 0; i < 3000; i++) begin
            ra = 2'($urandom_range(0, 3));
            rd = $urandom;
            if (ra == 2'd1 || ra == 2'd2) rd = rd & 32'hFFFFFF07;
            if (ra == 2'd0) rd = (rd & 32'hFFFFFFFC) | ($urandom_range(0, 3) == 0 ? 32'h2 : 32'h1);
            case ($urandom_range(0, 9))
                0, 1: cyc(ra, 1'b1, 1'b0, rd);
                2: cyc(ra, 1'b0, 1'b0, rd);
                default: cyc(ra, 1'b1, 1'b1, rd);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
